// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | audio_pkg                                                          |
// | Shared audio types, FSM state encoding, default sampling divider   |
// | and the saturating left-shift used by the optional gain stage.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package audio_pkg;

  // Signed 16-bit PCM sample
  typedef logic signed [15:0] sample_t;

  // Playback FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // 50 MHz / 2273 gives roughly a 22 kHz sampling tick
  localparam int DEFAULT_CLK_DIV = 2273;

  // Arithmetic left shift by 0..3 with saturation to the 16-bit signed range
  function automatic sample_t sat_shl16(input sample_t s, input logic [1:0] sh);
    logic signed [18:0] w;
    w = {{3{s[15]}}, s};
    w = w <<< sh;
    if (w > 19'sd32767) begin
      return 16'sh7fff;
    end else if (w < -19'sd32768) begin
      return 16'sh8000;
    end else begin
      return w[15:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo                                                          |
// | Single-clock FIFO with occupancy count. A write while full is      |
// | accepted only when a pop happens in the same cycle. The head entry |
// | is presented combinationally on rd_data.                           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a write
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_en);

  // Next pointer and count values; clear wins over any transfer
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + LW'(wr_ok) - LW'(rd_ok);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the count gates visibility
  always_ff @(posedge clk) begin
    if (wr_ok && !clr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_stream_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_stream_buffer                                               |
// | Elastic sample buffer between the flash reader and the audio path. |
// | Pre-fills before playback, releases one sample per sampling tick,  |
// | re-buffers after an underrun and exports the tick upstream.        |
// | Build option: SAMPLE_GAIN_EN adds gain_shift and a saturating      |
// | left-shift on the popped sample.                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sample_stream_buffer
  import audio_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int AFULL_LEVEL = 12,
  parameter int PREFILL     = 8
) (
  input  logic                   CLK50MHZ,
  input  logic                   reset,
  input  logic [15:0]            sample_in,
  input  logic                   sample_wr,
  input  logic                   play,
  input  logic                   flush,
`ifdef SAMPLE_GAIN_EN
  input  logic [1:0]             gain_shift,
`endif
  output logic                   pause,
  output logic                   sample_tick,
  output logic [15:0]            audio_out,
  output logic                   audio_strobe,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   overflow
);

  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_FILL = ST_FILL;
  localparam logic [1:0] S_RUN  = ST_RUN;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      audio_q, audio_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;
  logic             pause_q, pause_d;

  sample_t          fifo_head;
  sample_t          pop_sample;
  logic [LW-1:0]    fifo_level;
  logic [LW-1:0]    level_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             tick;
  logic             pop;
  logic             wr_req;
  logic             wr_acc;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK50MHZ),
    .reset   (reset),
    .clr     (flush),
    .wr_en   (wr_req),
    .wr_data (sample_in),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tick   = (state_q == S_RUN) && (div_q == DIV_LAST);
  // An empty FIFO is never bypassed: the tick becomes an underrun instead
  assign pop    = tick && !fifo_empty && !flush;
  assign wr_req = sample_wr && !flush;
  assign wr_acc = wr_req && (!fifo_full || pop);
  assign level_next = flush ? '0 : (fifo_level + LW'(wr_acc) - LW'(pop));

`ifdef SAMPLE_GAIN_EN
  assign pop_sample = sat_shl16(fifo_head, gain_shift);
`else
  assign pop_sample = fifo_head;
`endif

  assign sample_tick  = tick;
  assign audio_out    = audio_q;
  assign audio_strobe = strobe_q;
  assign level        = fifo_level;
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;
  assign pause        = pause_q;

  // Playback state transitions and the sampling divider that runs only in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (play) state_d = S_FILL;
      end
      S_FILL: begin
        if (!play) state_d = S_IDLE;
        else if (fifo_level >= LW'(PREFILL)) state_d = S_RUN;
      end
      S_RUN: begin
        if (!play) state_d = S_IDLE;
        else if (tick && fifo_empty) state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;

    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      div_d = tick ? '0 : (div_q + DIV_W'(1));
    end else begin
      div_d = '0;
    end
  end

  // Output sample, strobe, sticky flags and backpressure for the next cycle
  always_comb begin
    audio_d    = audio_q;
    strobe_d   = pop;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    pause_d    = (level_next >= LW'(AFULL_LEVEL));
    if (flush) begin
      audio_d    = '0;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      overflow_d = 1'b0;
      pause_d    = 1'b0;
    end else begin
      if (pop) audio_d = pop_sample;
      if (tick && fifo_empty) underrun_d = 1'b1;
      if (sample_wr && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  // Control and output registers
  always_ff @(posedge CLK50MHZ or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      audio_q    <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      pause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      audio_q    <= audio_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      pause_q    <= pause_d;
    end
  end

endmodule
`default_nettype wire
